// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer
// Brief    : Program-load and run-control sequencer for the MC14500B core.
// Revision : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12,
    parameter int BOOT_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_word,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic                  run_cmd,
    input  logic                  halt_cmd,
    input  logic                  step_cmd,
    input  logic                  cycle_done,
    output logic                  text_write,
    output logic [ADDR_WIDTH-1:0] text_write_address,
    output logic [DATA_WIDTH-1:0] text_data,
    output logic                  core_reset,
    output logic                  fetch_enable,
    output logic                  start_pulse,
    output logic [2:0]            state,
    output logic [15:0]           instr_count,
    output logic                  overflow_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_BOOT   = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_HALTED = 3'd5,
        S_STEP   = 3'd6
    } state_t;

    localparam logic [3:0] C_BOOT_LAST = 4'(BOOT_DELAY - 1);

    state_t                state_q, state_d;
    // Extra MSB flags that every address slot has been written.
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
    logic [3:0]            boot_cnt_q, boot_cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  core_reset_q, core_reset_d;
    logic                  fetch_q, fetch_d;
    logic                  start_q, start_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    logic                  w_accept;
    logic [15:0]           w_cnt_inc;

    assign load_ready = reset & ((state_q == S_IDLE) | (state_q == S_LOAD) |
                                 (state_q == S_HALTED));
    assign w_accept   = load_valid & load_ready;
    assign w_cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        boot_cnt_d = boot_cnt_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        start_d    = 1'b0;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (w_accept) begin
                    state_d = load_last ? S_IDLE : S_LOAD;
                    wr_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = load_word;
                    ptr_d   = (ADDR_WIDTH + 1)'(1);
                    ovf_d   = 1'b0;
                end else if (state_q == S_IDLE) begin
                    if (run_cmd) begin
                        state_d    = S_BOOT;
                        boot_cnt_d = 4'd0;
                        cnt_d      = 16'd0;
                    end
                end else if (step_cmd) begin
                    state_d = S_STEP;
                    start_d = 1'b1;
                end else if (run_cmd) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (ptr_q[ADDR_WIDTH]) begin
                        ovf_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wr_d    = 1'b1;
                        addr_d  = ptr_q[ADDR_WIDTH-1:0];
                        data_d  = load_word;
                        ptr_d   = ptr_q + 1'b1;
                        if (load_last) state_d = S_IDLE;
                    end
                end
            end
            S_BOOT: begin
                if (boot_cnt_q == C_BOOT_LAST) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                if (cycle_done) cnt_d = w_cnt_inc;
                // A halt that coincides with completion has nothing left to drain.
                if (halt_cmd) state_d = cycle_done ? S_HALTED : S_DRAIN;
            end
            S_DRAIN, S_STEP: begin
                if (cycle_done) begin
                    cnt_d   = w_cnt_inc;
                    state_d = S_HALTED;
                end
            end
            default: state_d = S_IDLE;
        endcase

        core_reset_d = (state_d == S_IDLE) | (state_d == S_LOAD);
        fetch_d      = (state_d == S_RUN) | (state_d == S_STEP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            boot_cnt_q   <= 4'd0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            core_reset_q <= 1'b1;
            fetch_q      <= 1'b0;
            start_q      <= 1'b0;
            cnt_q        <= 16'd0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            boot_cnt_q   <= boot_cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            core_reset_q <= core_reset_d;
            fetch_q      <= fetch_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign state              = state_q;
    assign text_write         = wr_q;
    assign text_write_address = addr_q;
    assign text_data          = data_q;
    assign core_reset         = core_reset_q;
    assign fetch_enable       = fetch_q;
    assign start_pulse        = start_q;
    assign instr_count        = cnt_q;
    assign overflow_err       = ovf_q;

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Run-control and program-load sequencer for the MC14500B core.
- Owns the text RAM write port and loads programs into it word by word from a host stream.
- Holds the core in reset while loading, then releases it and injects the start request into the req/ack fetch ring.
- Supports run, halt (drains the in-flight instruction) and single-step, and counts retired instructions.

Parameters:
- ADDR_WIDTH, 8, text RAM address width.
- DATA_WIDTH, 12, instruction word width (4-bit opcode + ADDR_WIDTH).
- BOOT_DELAY, 2, cycles core_reset stays deasserted before start_pulse; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset asserted.
- load_valid  input  1  host has a program word.
- load_word  input  DATA_WIDTH  program word.
- load_last  input  1  qualifies load_word as the final word.
- load_ready  output  1  sequencer accepts a word this cycle.
- run_cmd  input  1  single-cycle pulse: boot from IDLE, or resume from HALTED.
- halt_cmd  input  1  single-cycle pulse: stop after the current instruction.
- step_cmd  input  1  single-cycle pulse: execute one instruction from HALTED.
- cycle_done  input  1  single-cycle pulse when the ICU completes an instruction (ICU ack out).
- text_write  output  1  text RAM write strobe.
- text_write_address  output  ADDR_WIDTH  text RAM write address.
- text_data  output  DATA_WIDTH  text RAM write data.
- core_reset  output  1  active-high reset to the core blocks.
- fetch_enable  output  1  gates the fetch ring request path.
- start_pulse  output  1  one-cycle kick into the text RAM request input.
- state  output  3  encoded FSM state.
- instr_count  output  16  retired-instruction count, saturating.
- overflow_err  output  1  sticky: program exceeded 2^ADDR_WIDTH words.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, core_reset=1, fetch_enable=0, start_pulse=0, text_write=0.
  - Write address=0, text_data=0, instr_count=0, overflow_err=0, BOOT counter=0.
  - load_ready=0 while reset is asserted.
- State encoding: IDLE=0, LOAD=1, BOOT=2, RUN=3, DRAIN=4, HALTED=5, STEP=6.
- All outputs are registered Moore outputs, except load_ready, which is combinational from state.
- load_ready=1 only in IDLE, LOAD and HALTED.
- core_reset=1 in IDLE and LOAD, 0 otherwise.
- fetch_enable=1 only in RUN and STEP.
- Accept = load_valid & load_ready.
- IDLE/HALTED:
  - Accept -> LOAD. Write address restarts at 0 and overflow_err clears.
  - The word is written: text_write=1 in the next cycle with that address/data.
- LOAD:
  - Each accept produces exactly one text_write pulse, one cycle after acceptance, then the address increments.
  - An accept with load_last=1 writes its word, then -> IDLE.
  - Accept when the address has wrapped past 2^ADDR_WIDTH-1: word not written, overflow_err=1, -> IDLE.
- IDLE + run_cmd (and no accept) -> BOOT.
  - Entering BOOT clears instr_count and core_reset falls.
  - BOOT counts BOOT_DELAY cycles, then start_pulse=1 for exactly one cycle, coincident with entry to RUN.
- RUN:
  - Each cycle_done increments instr_count; saturates at 0xFFFF.
  - halt_cmd -> DRAIN.
  - halt_cmd together with cycle_done -> HALTED; that instruction is counted.
- DRAIN: fetch_enable=0; next cycle_done is counted -> HALTED. run_cmd and step_cmd are ignored.
- HALTED:
  - run_cmd -> RUN with one start_pulse.
  - step_cmd -> STEP with one start_pulse.
  - An accept starts a new load (core_reset re-asserts).
- STEP: on cycle_done, count it -> HALTED. halt_cmd in STEP is ignored (already single instruction).
- Command priority when simultaneous: accept > halt_cmd > step_cmd > run_cmd. Commands are ignored in states not listed above.
- text_write is never asserted outside LOAD (or the IDLE/HALTED acceptance cycle's follow-on).
- Reset asserted mid-load or mid-run aborts immediately; the partial program stays in RAM.

Test Plan:
- Load 3 words 0x1FF, 0x2A0, 0x3C5 (last on third), back-to-back valid -> three text_write pulses at addresses 0,1,2 with matching data, one cycle after each accept; state returns to 0; overflow_err=0.
- run_cmd in IDLE with BOOT_DELAY=2 -> core_reset falls next cycle; start_pulse high exactly one cycle, 2 cycles later; state=3; fetch_enable=1.
- RUN with 5 cycle_done pulses, then halt_cmd, then one more cycle_done -> state 4 then 5; instr_count=6; fetch_enable=0 from DRAIN onward.
- HALTED, step_cmd twice (each followed by cycle_done) -> two start_pulses; state 6 then 5 each time; instr_count increments by 1 per step.
- ADDR_WIDTH=2, stream 5 words without load_last -> 4 writes at 0..3; fifth not written; overflow_err=1; state=0.
- Pull reset low mid-RUN with instr_count=7 -> all outputs at reset values asynchronously; after release state=0, core_reset=1, load_ready=1.
